// File: rtl/kalman_result_reader.sv
// kalman_result_reader
// Double-buffered capture of the Kalman Mem2 result stream (clk_DSP domain).
// One WIP_flag high period is one frame. It is written into the write bank
// while the host reads the previous complete frame from the read bank.
// Banks swap atomically at frame end, the swap is deferred while the host
// holds lock_i, and a completed frame that gets overwritten before it could
// be swapped in is flagged on overrun_o.
//
// Ports
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   Mem2_we_i        result write strobe
//   Mem2_addrw_i     result write address
//   Mem2_data_i      result write data
//   WIP_flag_i       frame in progress
//   lock_i           host read lock, defers the bank swap
//   clr_i            clears overrun_o
//   rd_en_i          host read request
//   rd_addr_i        host read address
//   rd_data_o        32-bit slice of the word read, 2 cycles after rd_en_i
//   rd_valid_o       rd_data_o valid strobe
//   new_frame_o      one-cycle pulse on bank swap
//   frame_cnt_o      number of swapped frames
//   overrun_o        sticky: a completed frame was discarded
//   bank_o           bank currently readable by the host
module kalman_result_reader #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 36,
  parameter int unsigned RD_SHIFT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              Mem2_we_i,
  input  logic [ADDR_W-1:0] Mem2_addrw_i,
  input  logic [DATA_W-1:0] Mem2_data_i,
  input  logic              WIP_flag_i,
  input  logic              lock_i,
  input  logic              clr_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [31:0]       rd_data_o,
  output logic              rd_valid_o,
  output logic              new_frame_o,
  output logic [15:0]       frame_cnt_o,
  output logic              overrun_o,
  output logic              bank_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned RD_W  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic wip_q;
  logic rise_c;
  logic fall_c;
  logic swap_c;
  logic ovr_set_c;

  // Both banks in one array; the bank index is the top address bit.
  logic [DATA_W-1:0] mem [2*DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic              rd_pend_q;
  logic              unused_ram_c;

  assign rise_c = WIP_flag_i & ~wip_q;
  assign fall_c = ~WIP_flag_i & wip_q;

  // WIP edge detector; cleared by reset so a flag high at release is a rise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wip_q <= 1'b0;
    else          wip_q <= WIP_flag_i;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise_c) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (fall_c) state_d = lock_i ? PENDING : IDLE;
      end
      PENDING: begin
        if (!lock_i)     state_d = rise_c ? CAPTURE : IDLE;
        else if (rise_c) state_d = CAPTURE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM decoded actions: bank swap and frame discard.
  always_comb begin
    swap_c    = 1'b0;
    ovr_set_c = 1'b0;
    case (state_q)
      CAPTURE: swap_c = fall_c & ~lock_i;
      PENDING: begin
        swap_c    = ~lock_i;
        ovr_set_c = lock_i & rise_c;
      end
      default: ;
    endcase
  end

  // Swap bookkeeping and sticky overrun; set has priority over clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bank_o      <= 1'b0;
      new_frame_o <= 1'b0;
      frame_cnt_o <= '0;
      overrun_o   <= 1'b0;
    end else begin
      new_frame_o <= swap_c;
      if (swap_c) begin
        bank_o      <= ~bank_o;
        frame_cnt_o <= frame_cnt_o + CNT_W'(1);
      end
      if (ovr_set_c)  overrun_o <= 1'b1;
      else if (clr_i) overrun_o <= 1'b0;
    end
  end

  // Result writes always target the bank the host is not reading.
  always_ff @(posedge clk_i) begin
    if (Mem2_we_i) mem[{~bank_o, Mem2_addrw_i}] <= Mem2_data_i;
  end

  // Registered RAM read from the host bank as sampled with the request.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) ram_q <= mem[{bank_o, rd_addr_i}];
  end

  // Only the host slice leaves the block; remaining word bits are dropped.
  assign unused_ram_c = ^ram_q;

  // Output register stage of the read pipe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_pend_q  <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_pend_q  <= rd_en_i;
      rd_valid_o <= rd_pend_q;
      if (rd_pend_q) rd_data_o <= ram_q[RD_SHIFT +: RD_W];
    end
  end

endmodule

// File: tb/tb_kalman_result_reader.sv
// Self-checking bench for kalman_result_reader: directed frame scenarios plus
// randomized traffic compared cycle by cycle against a frame-level model.
module tb_kalman_result_reader;

  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DATA_W   = 36;
  localparam int unsigned RD_SHIFT = 4;
  localparam int unsigned DEPTH    = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              we;
  logic [ADDR_W-1:0] addrw;
  logic [DATA_W-1:0] wdata;
  logic              wip;
  logic              lock;
  logic              clr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              new_frame;
  logic [15:0]       frame_cnt;
  logic              overrun;
  logic              bank;

  int checks   = 0;
  int failures = 0;

  // Reference model: two frame buffers, host bank, a "completed frame waiting"
  // flag, and a two-deep queue of outstanding reads.
  logic [DATA_W-1:0] mm    [2][DEPTH];
  bit                known [2][DEPTH];
  bit                m_bank, m_wip, m_ready, m_over, m_nf;
  logic [15:0]       m_cnt;
  bit                v1, k1, m_rv, m_rdk;
  logic [31:0]       d1, m_rd;

  always #5 clk = ~clk;

  kalman_result_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_SHIFT(RD_SHIFT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .Mem2_we_i(we), .Mem2_addrw_i(addrw),
    .Mem2_data_i(wdata), .WIP_flag_i(wip), .lock_i(lock), .clr_i(clr),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .new_frame_o(new_frame), .frame_cnt_o(frame_cnt),
    .overrun_o(overrun), .bank_o(bank)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bank = 1'b0; m_wip = 1'b0; m_ready = 1'b0; m_over = 1'b0; m_nf = 1'b0;
    m_cnt = 16'd0; v1 = 1'b0; k1 = 1'b0; d1 = 32'd0;
    m_rv = 1'b0; m_rd = 32'd0; m_rdk = 1'b1;
  endtask

  task automatic quiet();
    we = 1'b0; clr = 1'b0; rd_en = 1'b0; addrw = '0; wdata = '0; rd_addr = '0;
  endtask

  // Advance one clock: update the model with the driven inputs, then compare.
  task automatic tick();
    bit rise, fall, swap, ovr_set;
    bit nk;
    logic [DATA_W-1:0] word;
    logic [31:0] nd;
    rise = wip && !m_wip;
    fall = !wip && m_wip;
    word = mm[m_bank][rd_addr];
    nd   = word[RD_SHIFT +: 32];
    nk   = known[m_bank][rd_addr];
    if (we) begin
      mm[!m_bank][addrw]    = wdata;
      known[!m_bank][addrw] = 1'b1;
    end
    // A finished frame is handed over as soon as the host is not locking.
    swap    = !lock && (fall || m_ready);
    ovr_set = m_ready && lock && rise;
    if (ovr_set)           m_ready = 1'b0;
    else if (fall && lock) m_ready = 1'b1;
    else if (swap)         m_ready = 1'b0;
    if (ovr_set)    m_over = 1'b1;
    else if (clr)   m_over = 1'b0;
    m_nf = swap;
    if (swap) begin
      m_bank = !m_bank;
      m_cnt  = m_cnt + 16'd1;
    end
    m_wip = wip;
    m_rv = v1;
    if (v1) begin
      m_rd  = d1;
      m_rdk = k1;
    end
    v1 = rd_en; d1 = nd; k1 = nk;
    @(posedge clk);
    #1;
    chk("bank", 32'(bank), 32'(m_bank));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("new_frame", 32'(new_frame), 32'(m_nf));
    chk("overrun", 32'(overrun), 32'(m_over));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    if (m_rdk) chk("rd_data", rd_data, m_rd);
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we = 1'b1; addrw = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  // Issue one read and check the data that comes back two cycles later.
  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid_early"}, 32'(rd_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk(tag, rd_data, exp);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_new_frame"}, 32'(new_frame), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_bank"}, 32'(bank), 32'd0);
  endtask

  task automatic rand_cycle();
    we    = 1'($urandom_range(0, 1));
    addrw = ADDR_W'($urandom);
    wdata = {4'($urandom), 32'($urandom)};
    if ($urandom_range(0, 3) == 0) lock = !lock;
    clr     = ($urandom_range(0, 7) == 0);
    rd_en   = 1'($urandom_range(0, 1));
    rd_addr = ADDR_W'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; wip = 1'b0; lock = 1'b0;
    quiet();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Full frame of 512 writes, no lock.
    wip = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) write(ADDR_W'(i), DATA_W'(i * 3));
    wip = 1'b0;
    tick();
    chk("f1_new_frame", 32'(new_frame), 32'd1);
    chk("f1_bank", 32'(bank), 32'd1);
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    tick();
    chk("f1_pulse_len", 32'(new_frame), 32'd0);
    read_check("f1_rd100", 9'd100, 32'd18);

    // Lock held across frame end defers the swap.
    lock = 1'b1;
    wip  = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) write(ADDR_W'($urandom), {4'($urandom), 32'($urandom)});
    wip = 1'b0;
    tick();
    chk("lk_bank_held", 32'(bank), 32'd1);
    chk("lk_no_pulse", 32'(new_frame), 32'd0);
    tick(); tick();
    lock = 1'b0;
    tick();
    chk("lk_new_frame", 32'(new_frame), 32'd1);
    chk("lk_bank", 32'(bank), 32'd0);
    chk("lk_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("lk_overrun", 32'(overrun), 32'd0);

    // Pending frame overwritten by the next one while still locked.
    lock = 1'b1;
    wip  = 1'b1;
    tick();
    write(9'd7, 36'h1_2345_6780);
    wip = 1'b0;
    tick();
    tick();
    wip = 1'b1;
    tick();
    chk("ov_set", 32'(overrun), 32'd1);
    chk("ov_cnt_held", 32'(frame_cnt), 32'd2);
    write(9'd7, 36'hA_BCDE_F010);
    wip = 1'b0;
    tick();
    lock = 1'b0;
    tick();
    chk("ov_swap_cnt", 32'(frame_cnt), 32'd3);
    chk("ov_swap_bank", 32'(bank), 32'd1);
    chk("ov_sticky", 32'(overrun), 32'd1);
    read_check("ov_frame2_data", 9'd7, 32'hABCD_EF01);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ov_clr", 32'(overrun), 32'd0);

    // Last write coincides with the falling WIP edge.
    wip = 1'b1;
    tick();
    write(9'd5, 36'h0_0000_0050);
    wip = 1'b0;
    write(9'd511, 36'hF_FFFF_FFF0);
    chk("lw_new_frame", 32'(new_frame), 32'd1);
    chk("lw_bank", 32'(bank), 32'd0);
    read_check("lw_rd511", 9'd511, 32'hFFFF_FFFF);

    // Back-to-back reads straddling the swap cycle.
    wip = 1'b1;
    tick();
    write(9'd5, 36'h0_0000_0AA0);
    wip = 1'b0; rd_en = 1'b1; rd_addr = 9'd5;
    tick();
    tick();
    rd_en = 1'b0;
    chk("sw_old_valid", 32'(rd_valid), 32'd1);
    chk("sw_old_data", rd_data, 32'h5);
    tick();
    chk("sw_new_valid", 32'(rd_valid), 32'd1);
    chk("sw_new_data", rd_data, 32'hAA);
    tick();
    chk("sw_valid_drop", 32'(rd_valid), 32'd0);

    // Randomized frames with random lock, clear, write and read traffic.
    for (int f = 0; f < 12; f++) begin
      int len;
      int gap;
      len = $urandom_range(20, 60);
      gap = $urandom_range(2, 8);
      wip = 1'b1;
      for (int c = 0; c < len; c++) begin rand_cycle(); tick(); end
      wip = 1'b0;
      for (int c = 0; c < gap; c++) begin rand_cycle(); tick(); end
    end

    // Reset in the middle of a frame with a read in flight.
    quiet();
    lock = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    wip = 1'b1;
    tick();
    write(9'd3, 36'h0_0000_1230);
    rd_en = 1'b1; rd_addr = 9'd3;
    tick();
    rd_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    write(9'd4, 36'h0_0000_4440);
    write(9'd6, 36'h0_0000_6660);
    wip = 1'b0;
    tick();
    chk("rs_bank", 32'(bank), 32'd1);
    chk("rs_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("rs_new_frame", 32'(new_frame), 32'd1);
    read_check("rs_rd6", 9'd6, 32'h666);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
